// File: rtl/sgn_detect_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sgn_detect_pipe: segmented carry-propagate sign detector for carry-save    |
// | (VS, VC) pairs, one result per clock. SGN_ZERO_DETECT_EN adds zero output. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sgn_detect_pipe #(
  parameter int W      = 16,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         data_in,
  input  logic [W-1:0] VS,
  input  logic [W-1:0] VC,
  input  logic         hold,
  input  logic         flush,
  output logic         sgn,
  output logic         data_out
`ifdef SGN_ZERO_DETECT_EN
  ,
  output logic         zero
`endif
);

  localparam int SEG  = W / STAGES;
  localparam int SEGP = SEG + 1;

  // Level k keeps only operand segments k..STAGES-1, so levels are packed back to back.
  function automatic int lvl_off(input int k);
    return k * W - (SEG * k * (k - 1)) / 2;
  endfunction

  localparam int TOT = lvl_off(STAGES);

  logic [TOT-1:0]    r_vs, r_vc, w_vs_nxt, w_vc_nxt;
  logic [STAGES-1:0] r_c, r_v, w_c_nxt, w_v_nxt;
  logic              w_top_msb;
`ifdef SGN_ZERO_DETECT_EN
  logic [STAGES-1:0] r_z, w_z_nxt;
  logic              w_top_zero;
`endif

  assign w_vs_nxt[W-1:0] = VS;
  assign w_vc_nxt[W-1:0] = VC;
  assign w_c_nxt[0]      = 1'b0;
  assign w_v_nxt[0]      = data_in;
`ifdef SGN_ZERO_DETECT_EN
  assign w_z_nxt[0]      = 1'b1;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int O = lvl_off(k);
    if (k < STAGES - 1) begin : g_mid
      localparam int LW = W - k * SEG;
      logic [SEG:0] w_sum;
      assign w_sum = {1'b0, r_vs[O +: SEG]} + {1'b0, r_vc[O +: SEG]} + SEGP'(r_c[k]);
      assign w_vs_nxt[O+LW +: LW-SEG] = r_vs[O+SEG +: LW-SEG];
      assign w_vc_nxt[O+LW +: LW-SEG] = r_vc[O+SEG +: LW-SEG];
      assign w_c_nxt[k+1] = w_sum[SEG];
      assign w_v_nxt[k+1] = r_v[k];
`ifdef SGN_ZERO_DETECT_EN
      assign w_z_nxt[k+1] = r_z[k] & (w_sum[SEG-1:0] == '0);
`else
      logic w_unused_bits;
      assign w_unused_bits = ^w_sum[SEG-1:0];
`endif
    end else begin : g_last
      // Carry out of the top segment is the discarded mod-2^W overflow.
      logic [SEG-1:0] w_sum;
      assign w_sum     = r_vs[O +: SEG] + r_vc[O +: SEG] + SEG'(r_c[k]);
      assign w_top_msb = w_sum[SEG-1];
`ifdef SGN_ZERO_DETECT_EN
      assign w_top_zero = r_z[k] & (w_sum == '0);
`else
      logic w_unused_bits;
      assign w_unused_bits = ^w_sum;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vs     <= '0;
      r_vc     <= '0;
      r_c      <= '0;
      r_v      <= '0;
      sgn      <= 1'b0;
      data_out <= 1'b0;
`ifdef SGN_ZERO_DETECT_EN
      r_z      <= '0;
      zero     <= 1'b0;
`endif
    end else if (flush) begin
      r_v      <= '0;
      data_out <= 1'b0;
    end else if (!hold) begin
      r_vs     <= w_vs_nxt;
      r_vc     <= w_vc_nxt;
      r_c      <= w_c_nxt;
      r_v      <= w_v_nxt;
      data_out <= r_v[STAGES-1];
`ifdef SGN_ZERO_DETECT_EN
      r_z      <= w_z_nxt;
`endif
      if (r_v[STAGES-1]) begin
        sgn  <= ~w_top_msb;
`ifdef SGN_ZERO_DETECT_EN
        zero <= w_top_zero;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sgn_detect_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sgn_detect_pipe: scoreboard bench for STAGES = 4, 1 and 16 builds.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sgn_detect_pipe;

  localparam int W = 16;

  logic         clk     = 1'b0;
  logic         reset   = 1'b0;
  logic         data_in = 1'b0;
  logic         hold    = 1'b0;
  logic         flush   = 1'b0;
  logic [W-1:0] vs_in   = '0;
  logic [W-1:0] vc_in   = '0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        s;
    logic        z;
    logic [31:0] c;
  } exp_t;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, expv, $time);
    end
  endtask

  for (genvar i = 0; i < 3; i++) begin : g_dut
    localparam int ST = (i == 0) ? 4 : ((i == 1) ? 1 : 16);

    logic         sgn_o;
    logic         dout_o;
`ifdef SGN_ZERO_DETECT_EN
    logic         zero_o;
`endif
    exp_t         q[$];
    exp_t         e;
    int           cyc      = 0;
    logic         exp_dout = 1'b0;
    logic         exp_sgn  = 1'b0;
    logic         exp_zero = 1'b0;
    logic [W-1:0] sum;

    sgn_detect_pipe #(.W(W), .STAGES(ST)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .data_in  (data_in),
      .VS       (vs_in),
      .VC       (vc_in),
      .hold     (hold),
      .flush    (flush),
      .sgn      (sgn_o),
      .data_out (dout_o)
`ifdef SGN_ZERO_DETECT_EN
      ,
      .zero     (zero_o)
`endif
    );

    // Reference: cyc counts non-held edges; a pair is due ST such edges after entry.
    always @(posedge clk or posedge reset) begin
      if (reset) begin
        q.delete();
        cyc      = 0;
        exp_dout = 1'b0;
        exp_sgn  = 1'b0;
        exp_zero = 1'b0;
      end else if (flush) begin
        q.delete();
        exp_dout = 1'b0;
      end else if (!hold) begin
        cyc++;
        exp_dout = 1'b0;
        if (q.size() > 0 && q[0].c == 32'(cyc)) begin
          e        = q.pop_front();
          exp_dout = 1'b1;
          exp_sgn  = e.s;
          exp_zero = e.z;
        end
        if (data_in) begin
          sum = vs_in + vc_in;
          q.push_back({~sum[W-1], (sum == '0), 32'(cyc + ST)});
        end
      end
    end

    always @(negedge clk) begin
      check($sformatf("S%0d data_out", ST), 32'(dout_o), 32'(exp_dout));
      check($sformatf("S%0d sgn", ST), 32'(sgn_o), 32'(exp_sgn));
`ifdef SGN_ZERO_DETECT_EN
      check($sformatf("S%0d zero", ST), 32'(zero_o), 32'(exp_zero));
`endif
    end
  end

  task automatic step(input logic din, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic h, input logic f);
    data_in = din;
    vs_in   = a;
    vc_in   = b;
    hold    = h;
    flush   = f;
    @(posedge clk);
    #1;
    data_in = 1'b0;
    hold    = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    step(1'b1, a, b, 1'b0, 1'b0);
  endtask

  task automatic send_rand();
    step(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, W'($urandom), W'($urandom), 1'b0, 1'b0);
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(6);

    send(16'h0003, 16'hFFFE);
    idle(20);

    // Full carry ripple and wrap-to-zero cases
    send(16'h7FFF, 16'h0001);
    send(16'hFFFF, 16'h0001);
    send(16'h8000, 16'h8000);
    send(16'h1234, 16'hEDCC);
    send(16'h8000, 16'h0000);
    idle(20);

    repeat (8) send_rand();
    idle(20);

    repeat (4) send_rand();
    repeat (2) step(1'b1, W'($urandom), W'($urandom), 1'b1, 1'b0);
    repeat (4) send_rand();
    idle(20);

    send_rand();
    idle(3);
    repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0);
    idle(20);

    repeat (3) send_rand();
    step(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b1);
    idle(20);

    repeat (3) send_rand();
    step(1'b1, W'($urandom), W'($urandom), 1'b1, 1'b1);
    idle(20);

    // Asynchronous reset between clock edges with pairs in flight
    repeat (3) send_rand();
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(20);

    repeat (300)
      step($urandom_range(0, 3) != 0, W'($urandom), W'($urandom),
           $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
    idle(24);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
